btb_set_assoc: RTL and testbench



---
 rtl/btb_set_assoc_pkg.sv | 15 +
 rtl/btb_way_array.sv | 68 ++++++
 rtl/btb_set_assoc.sv | 135 +++++++++++++
 tb/tb_btb_set_assoc.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/btb_set_assoc_pkg.sv
// Shared BTB constants: default geometry for the set-associative branch target buffer
// and a helper that derives the way-number width from the associativity.
package btb_set_assoc_pkg;

  localparam int BTB_INDEX_WIDTH  = 4;
  localparam int BTB_TAG_WIDTH    = 26;
  localparam int BTB_TARGET_WIDTH = 32;
  localparam int BTB_WAYS         = 2;

  // A direct-mapped table still carries a 1-bit way number so hit_way never collapses to zero width.
  function automatic int btb_way_width(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/btb_way_array.sv
// One BTB way: per-set valid/tag/target storage with a combinational lookup port,
// two tag probes (update and invalidate sets), a single write port and a valid-clear port.
module btb_way_array
  import btb_set_assoc_pkg::*;
#(
  parameter int INDEX_WIDTH  = BTB_INDEX_WIDTH,
  parameter int TAG_WIDTH    = BTB_TAG_WIDTH,
  parameter int TARGET_WIDTH = BTB_TARGET_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [INDEX_WIDTH-1:0]  rd_index,
  input  logic [TAG_WIDTH-1:0]    rd_tag,
  output logic                    rd_hit,
  output logic [TARGET_WIDTH-1:0] rd_target,
  input  logic [INDEX_WIDTH-1:0]  upd_index,
  input  logic [TAG_WIDTH-1:0]    upd_tag,
  output logic                    upd_hit,
  output logic                    upd_occupied,
  input  logic [INDEX_WIDTH-1:0]  inv_index,
  input  logic [TAG_WIDTH-1:0]    inv_tag,
  output logic                    inv_hit,
  input  logic                    wr_en,
  input  logic [INDEX_WIDTH-1:0]  wr_index,
  input  logic [TAG_WIDTH-1:0]    wr_tag,
  input  logic [TARGET_WIDTH-1:0] wr_target,
  input  logic                    clr_en,
  input  logic [INDEX_WIDTH-1:0]  clr_index,
  input  logic                    flush
);

  localparam int SETS = 2 ** INDEX_WIDTH;

  logic [SETS-1:0]         valid;
  logic [TAG_WIDTH-1:0]    tag_mem    [SETS];
  logic [TARGET_WIDTH-1:0] target_mem [SETS];

  assign rd_hit       = valid[rd_index] && (tag_mem[rd_index] == rd_tag);
  assign rd_target    = target_mem[rd_index];
  assign upd_hit      = valid[upd_index] && (tag_mem[upd_index] == upd_tag);
  assign upd_occupied = valid[upd_index];
  assign inv_hit      = valid[inv_index] && (tag_mem[inv_index] == inv_tag);

  // Write is applied last so a same-cycle write beats both flush and clear of that entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= '0;
    end else begin
      if (flush) begin
        valid <= '0;
      end else if (clr_en) begin
        valid[clr_index] <= 1'b0;
      end
      if (wr_en) begin
        valid[wr_index] <= 1'b1;
      end
    end
  end

  // Tag and target storage is deliberately not cleared on reset; valid bits guard it.
  always_ff @(posedge clk) begin
    if (!reset && wr_en) begin
      tag_mem[wr_index]    <= wr_tag;
      target_mem[wr_index] <= wr_target;
    end
  end

endmodule

// File: rtl/btb_set_assoc.sv
// N-way set-associative branch target buffer: combinational IF-stage lookup, update/invalidate
// from ID/EX one edge later, round-robin victim per set once every way in the set is valid.
module btb_set_assoc
  import btb_set_assoc_pkg::*;
#(
  parameter int INDEX_WIDTH  = BTB_INDEX_WIDTH,
  parameter int TAG_WIDTH    = BTB_TAG_WIDTH,
  parameter int TARGET_WIDTH = BTB_TARGET_WIDTH,
  parameter int WAYS         = BTB_WAYS,
  parameter int WAY_WIDTH    = btb_way_width(WAYS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [INDEX_WIDTH-1:0]  if_index,
  input  logic [TAG_WIDTH-1:0]    if_tag,
  output logic                    hit,
  output logic [TARGET_WIDTH-1:0] hit_target,
  output logic [WAY_WIDTH-1:0]    hit_way,
  input  logic                    upd_valid,
  input  logic [INDEX_WIDTH-1:0]  upd_index,
  input  logic [TAG_WIDTH-1:0]    upd_tag,
  input  logic [TARGET_WIDTH-1:0] upd_target,
  input  logic                    inv_valid,
  input  logic [INDEX_WIDTH-1:0]  inv_index,
  input  logic [TAG_WIDTH-1:0]    inv_tag,
  input  logic                    flush
);

  localparam int SETS = 2 ** INDEX_WIDTH;

  logic [WAYS-1:0]         look_hit;
  logic [TARGET_WIDTH-1:0] look_target [WAYS];
  logic [WAYS-1:0]         upd_hit;
  logic [WAYS-1:0]         upd_occupied;
  logic [WAYS-1:0]         inv_hit;
  logic [WAYS-1:0]         wr_en;
  logic [WAYS-1:0]         clr_en;

  logic [WAY_WIDTH-1:0]    rr [SETS];
  logic [WAY_WIDTH-1:0]    rr_cur;
  logic [WAY_WIDTH-1:0]    rr_next;
  logic [WAY_WIDTH-1:0]    upd_hit_way;
  logic [WAY_WIDTH-1:0]    free_way;
  logic [WAY_WIDTH-1:0]    wr_way;
  logic                    upd_any_hit;
  logic                    set_full;
  logic                    rr_advance;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    btb_way_array #(
      .INDEX_WIDTH (INDEX_WIDTH),
      .TAG_WIDTH   (TAG_WIDTH),
      .TARGET_WIDTH(TARGET_WIDTH)
    ) u_way (
      .clk         (clk),
      .reset       (reset),
      .rd_index    (if_index),
      .rd_tag      (if_tag),
      .rd_hit      (look_hit[w]),
      .rd_target   (look_target[w]),
      .upd_index   (upd_index),
      .upd_tag     (upd_tag),
      .upd_hit     (upd_hit[w]),
      .upd_occupied(upd_occupied[w]),
      .inv_index   (inv_index),
      .inv_tag     (inv_tag),
      .inv_hit     (inv_hit[w]),
      .wr_en       (wr_en[w]),
      .wr_index    (upd_index),
      .wr_tag      (upd_tag),
      .wr_target   (upd_target),
      .clr_en      (clr_en[w]),
      .clr_index   (inv_index),
      .flush       (flush)
    );

    assign wr_en[w]  = upd_valid && (wr_way == WAY_WIDTH'(w));
    assign clr_en[w] = inv_valid && inv_hit[w];
  end

  // Scanning from the top way down lets the lowest matching way win.
  always_comb begin
    hit        = 1'b0;
    hit_target = '0;
    hit_way    = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (look_hit[w]) begin
        hit        = 1'b1;
        hit_target = look_target[w];
        hit_way    = WAY_WIDTH'(w);
      end
    end
  end

  always_comb begin
    upd_hit_way = '0;
    free_way    = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (upd_hit[w]) begin
        upd_hit_way = WAY_WIDTH'(w);
      end
      if (!upd_occupied[w]) begin
        free_way = WAY_WIDTH'(w);
      end
    end
  end

  assign upd_any_hit = |upd_hit;
  assign set_full    = &upd_occupied;
  assign rr_cur      = rr[upd_index];
  assign rr_next     = (rr_cur == WAY_WIDTH'(WAYS - 1)) ? '0 : rr_cur + 1'b1;
  assign rr_advance  = upd_valid && !upd_any_hit && set_full;

  // In-place rewrite first, then the lowest free way, and only a full set consumes the rr pointer.
  always_comb begin
    if (upd_any_hit) begin
      wr_way = upd_hit_way;
    end else if (!set_full) begin
      wr_way = free_way;
    end else begin
      wr_way = rr_cur;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < SETS; s++) begin
        rr[s] <= '0;
      end
    end else if (rr_advance) begin
      rr[upd_index] <= rr_next;
    end
  end

endmodule

// File: tb/tb_btb_set_assoc.sv
// Self-checking bench for btb_set_assoc: directed scenarios plus randomized traffic,
// each lookup compared against a per-set array model of the BTB.
module tb_btb_set_assoc;
  import btb_set_assoc_pkg::*;

  localparam int IW   = 4;
  localparam int TW   = 26;
  localparam int GW   = 32;
  localparam int WAYS = 2;
  localparam int WW   = 1;
  localparam int SETS = 16;

  logic          clk;
  logic          reset;
  logic [IW-1:0] if_index;
  logic [TW-1:0] if_tag;
  logic          hit;
  logic [GW-1:0] hit_target;
  logic [WW-1:0] hit_way;
  logic          upd_valid;
  logic [IW-1:0] upd_index;
  logic [TW-1:0] upd_tag;
  logic [GW-1:0] upd_target;
  logic          inv_valid;
  logic [IW-1:0] inv_index;
  logic [TW-1:0] inv_tag;
  logic          flush;

  int vectors     = 0;
  int miscompares = 0;

  bit            m_val [SETS][WAYS];
  logic [TW-1:0] m_tag [SETS][WAYS];
  logic [GW-1:0] m_tgt [SETS][WAYS];
  int            m_rr  [SETS];

  btb_set_assoc #(
    .INDEX_WIDTH (IW),
    .TAG_WIDTH   (TW),
    .TARGET_WIDTH(GW),
    .WAYS        (WAYS),
    .WAY_WIDTH   (WW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .if_index  (if_index),
    .if_tag    (if_tag),
    .hit       (hit),
    .hit_target(hit_target),
    .hit_way   (hit_way),
    .upd_valid (upd_valid),
    .upd_index (upd_index),
    .upd_tag   (upd_tag),
    .upd_target(upd_target),
    .inv_valid (inv_valid),
    .inv_index (inv_index),
    .inv_tag   (inv_tag),
    .flush     (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {hit, hit_way, hit_target} for a lookup of the current model contents.
  function automatic logic [WW+GW:0] model_lookup(input int idx, input logic [TW-1:0] t);
    for (int w = 0; w < WAYS; w++) begin
      if (m_val[idx][w] && m_tag[idx][w] == t) return {1'b1, WW'(w), m_tgt[idx][w]};
    end
    return '0;
  endfunction

  // Applies one clock edge of the BTB rules to the model, deciding everything from pre-edge state.
  task automatic model_edge();
    int u, ii, uw, iw;
    bit adv;
    u = int'(upd_index);
    ii = int'(inv_index);
    uw = -1;
    iw = -1;
    adv = 1'b0;
    if (reset) begin
      for (int s = 0; s < SETS; s++) begin
        m_rr[s] = 0;
        for (int w = 0; w < WAYS; w++) m_val[s][w] = 1'b0;
      end
      return;
    end
    if (upd_valid) begin
      for (int w = 0; w < WAYS; w++)
        if (uw < 0 && m_val[u][w] && m_tag[u][w] == upd_tag) uw = w;
      for (int w = 0; w < WAYS; w++)
        if (uw < 0 && !m_val[u][w]) uw = w;
      if (uw < 0) begin
        uw = m_rr[u];
        adv = 1'b1;
      end
    end
    if (inv_valid) begin
      for (int w = 0; w < WAYS; w++)
        if (iw < 0 && m_val[ii][w] && m_tag[ii][w] == inv_tag) iw = w;
    end
    if (flush) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++) m_val[s][w] = 1'b0;
    end
    if (iw >= 0) m_val[ii][iw] = 1'b0;
    if (upd_valid) begin
      m_val[u][uw] = 1'b1;
      m_tag[u][uw] = upd_tag;
      m_tgt[u][uw] = upd_target;
      if (adv) m_rr[u] = (m_rr[u] + 1) % WAYS;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    reset      = 1'b0;
    flush      = 1'b0;
    upd_valid  = 1'b0;
    upd_index  = '0;
    upd_tag    = '0;
    upd_target = '0;
    inv_valid  = 1'b0;
    inv_index  = '0;
    inv_tag    = '0;
    if_index   = '0;
    if_tag     = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset    = 1'b0;
    if_index = 4'd3;
    if_tag   = 26'h3FFFFFF;
    #1;
    vectors++;
    if ({hit, hit_way, hit_target} !== 34'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_lookup: got %h required %h", {hit, hit_way, hit_target}, 34'h0);
    end
    tick();
  endtask

  task automatic test_alloc_rr();
    logic [TW-1:0] tags [4] = '{26'h12, 26'h34, 26'h56, 26'h78};
    logic [GW-1:0] tgts [4] = '{32'h100, 32'h110, 32'h120, 32'h130};
    logic [WW+GW:0] exp;
    clear_inputs();
    for (int i = 0; i < 4; i++) begin
      upd_valid  = 1'b1;
      upd_index  = 4'd5;
      upd_tag    = tags[i];
      upd_target = tgts[i];
      if_index   = 4'd5;
      if_tag     = tags[i];
      #1;
      vectors++;
      exp = model_lookup(5, if_tag);
      if ({hit, hit_way, hit_target} !== exp || (i == 0 && hit !== 1'b0)) begin
        miscompares++;
        $display("[TB] FAIL same_cycle_upd%0d: got %h required %h", i, {hit, hit_way, hit_target}, exp);
      end
      tick();
      upd_valid = 1'b0;
      #1;
      vectors++;
      exp = model_lookup(5, if_tag);
      if ({hit, hit_way, hit_target} !== exp) begin
        miscompares++;
        $display("[TB] FAIL after_upd%0d: got %h required %h", i, {hit, hit_way, hit_target}, exp);
      end
      if (i == 0 && {hit, hit_way, hit_target} !== {1'b1, 1'b0, 32'h100}) begin
        miscompares++;
        $display("[TB] FAIL first_alloc_way0: got %h required %h", {hit, hit_way, hit_target}, {1'b1, 1'b0, 32'h100});
      end
    end
    if_tag = 26'h12;
    #1;
    vectors++;
    if (hit !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL evicted_0x12: got hit=%0b required 0", hit);
    end
    if_tag = 26'h56;
    #1;
    vectors++;
    if ({hit, hit_way, hit_target} !== {1'b1, 1'b0, 32'h120}) begin
      miscompares++;
      $display("[TB] FAIL rr_way0_0x56: got %h required %h", {hit, hit_way, hit_target}, {1'b1, 1'b0, 32'h120});
    end
    upd_valid  = 1'b1;
    upd_tag    = 26'h78;
    upd_target = 32'h200;
    tick();
    upd_valid = 1'b0;
    if_tag    = 26'h78;
    #1;
    vectors++;
    if ({hit, hit_way, hit_target} !== {1'b1, 1'b1, 32'h200}) begin
      miscompares++;
      $display("[TB] FAIL inplace_0x78: got %h required %h", {hit, hit_way, hit_target}, {1'b1, 1'b1, 32'h200});
    end
    tick();
  endtask

  task automatic test_invalidate();
    clear_inputs();
    inv_valid = 1'b1;
    inv_index = 4'd5;
    inv_tag   = 26'h78;
    if_index  = 4'd5;
    if_tag    = 26'h78;
    tick();
    inv_valid = 1'b0;
    #1;
    vectors++;
    if (hit !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL inv_miss: got hit=%0b required 0", hit);
    end
    upd_valid  = 1'b1;
    upd_index  = 4'd5;
    upd_tag    = 26'h9A;
    upd_target = 32'h300;
    tick();
    upd_tag    = 26'hBC;
    upd_target = 32'h310;
    if_tag     = 26'h9A;
    #1;
    vectors++;
    if ({hit, hit_way, hit_target} !== {1'b1, 1'b1, 32'h300}) begin
      miscompares++;
      $display("[TB] FAIL freed_way_fill: got %h required %h", {hit, hit_way, hit_target}, {1'b1, 1'b1, 32'h300});
    end
    tick();
    upd_valid = 1'b0;
    if_tag    = 26'hBC;
    #1;
    vectors++;
    if ({hit, hit_way, hit_target} !== {1'b1, 1'b0, 32'h310}) begin
      miscompares++;
      $display("[TB] FAIL rr_after_inplace: got %h required %h", {hit, hit_way, hit_target}, {1'b1, 1'b0, 32'h310});
    end
    tick();
  endtask

  task automatic test_simultaneous();
    logic [WW+GW:0] exp;
    clear_inputs();
    inv_valid  = 1'b1;
    inv_index  = 4'd5;
    inv_tag    = 26'h9A;
    upd_valid  = 1'b1;
    upd_index  = 4'd5;
    upd_tag    = 26'h9A;
    upd_target = 32'h333;
    tick();
    inv_tag    = 26'hBC;
    upd_index  = 4'd6;
    upd_tag    = 26'h11;
    upd_target = 32'h444;
    if_index   = 4'd5;
    if_tag     = 26'h9A;
    #1;
    vectors++;
    if ({hit, hit_way, hit_target} !== {1'b1, 1'b1, 32'h333}) begin
      miscompares++;
      $display("[TB] FAIL inv_upd_same: got %h required %h", {hit, hit_way, hit_target}, {1'b1, 1'b1, 32'h333});
    end
    tick();
    clear_inputs();
    if_index = 4'd5;
    if_tag   = 26'hBC;
    #1;
    vectors++;
    if (hit !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL inv_other_set: got hit=%0b required 0", hit);
    end
    if_index = 4'd6;
    if_tag   = 26'h11;
    #1;
    vectors++;
    exp = model_lookup(6, if_tag);
    if ({hit, hit_way, hit_target} !== exp) begin
      miscompares++;
      $display("[TB] FAIL upd_other_set: got %h required %h", {hit, hit_way, hit_target}, exp);
    end
    tick();
    flush      = 1'b1;
    upd_valid  = 1'b1;
    upd_index  = 4'd2;
    upd_tag    = 26'h7;
    upd_target = 32'h40;
    tick();
    clear_inputs();
    if_index = 4'd2;
    if_tag   = 26'h7;
    #1;
    vectors++;
    if ({hit, hit_way, hit_target} !== {1'b1, 1'b0, 32'h40}) begin
      miscompares++;
      $display("[TB] FAIL flush_upd_kept: got %h required %h", {hit, hit_way, hit_target}, {1'b1, 1'b0, 32'h40});
    end
    if_index = 4'd5;
    if_tag   = 26'h9A;
    #1;
    vectors++;
    if (hit !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL flush_cleared: got hit=%0b required 0", hit);
    end
    tick();
    reset      = 1'b1;
    upd_valid  = 1'b1;
    upd_index  = 4'd2;
    upd_tag    = 26'h8;
    upd_target = 32'h50;
    tick();
    clear_inputs();
    if_index = 4'd2;
    if_tag   = 26'h8;
    #1;
    vectors++;
    if (hit !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_drops_upd: got hit=%0b required 0", hit);
    end
    if_tag = 26'h7;
    #1;
    vectors++;
    if (hit !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_clears: got hit=%0b required 0", hit);
    end
    tick();
  endtask

  task automatic test_random();
    logic [WW+GW:0] exp;
    clear_inputs();
    for (int n = 0; n < 500; n++) begin
      reset      = ($urandom_range(0, 99) == 0);
      flush      = ($urandom_range(0, 39) == 0);
      upd_valid  = ($urandom_range(0, 1) == 1);
      upd_index  = IW'($urandom_range(0, 3));
      upd_tag    = TW'($urandom_range(0, 5));
      upd_target = $urandom;
      inv_valid  = ($urandom_range(0, 3) == 0);
      inv_index  = IW'($urandom_range(0, 3));
      inv_tag    = TW'($urandom_range(0, 5));
      if_index   = IW'($urandom_range(0, 3));
      if_tag     = ($urandom_range(0, 9) == 0) ? TW'($urandom) : TW'($urandom_range(0, 5));
      #1;
      vectors++;
      exp = model_lookup(int'(if_index), if_tag);
      if ({hit, hit_way, hit_target} !== exp) begin
        miscompares++;
        $display("[TB] FAIL random_%0d: idx=%0d tag=%h got %h required %h",
                 n, if_index, if_tag, {hit, hit_way, hit_target}, exp);
      end
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    @(negedge clk);
    test_reset();
    test_alloc_rr();
    test_invalidate();
    test_simultaneous();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
